// File: rtl/alu_rr_scheduler_if.sv
// Requester-side bundle for alu_rr_scheduler: packed per-requester requests plus
// the one-hot result pulse returned to whichever requester was served.
//
// Handshake: requester i transfers on a rising edge where req_valid[i] && req_ready[i];
// while req_valid[i]=1 and req_ready[i]=0 the requester holds req_a/req_b/req_op stable.
// rsp_valid is a one-cycle one-hot pulse with no backpressure; rsp_data holds until the next capture.
interface alu_rr_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [4*NUM_REQ-1:0] req_a;
  logic [4*NUM_REQ-1:0] req_b;
  logic [2*NUM_REQ-1:0] req_op;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic signed [4:0]    rsp_data;

  modport master (
    output req_valid, req_a, req_b, req_op,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one registered 4-bit ALU among NUM_REQ requesters.
// One operation in flight at a time: IDLE (arbitrate) -> WAIT (ALU latency) -> RESP (pulse).
module alu_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  alu_rr_scheduler_if.slave          req_if,
  output logic [3:0]                 alu_a,
  output logic [3:0]                 alu_b,
  output logic [1:0]                 alu_op,
  input  logic signed [4:0]          alu_c,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [1:0]                 dbg_state
);
  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      scan_idx;
  logic [PW-1:0]      winner;
  logic               found;
  logic [2:0]         lat_cnt;
  logic [NUM_REQ-1:0] ready_vec;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic signed [4:0]  rsp_data_q;
  logic [3:0]         win_a, win_b;
  logic [1:0]         win_op;
  logic               accept, capture;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins last.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = PW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_if.req_valid[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  always_comb begin
    win_a  = '0;
    win_b  = '0;
    win_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PW'(i) == winner) begin
        win_a  = req_if.req_a[4*i +: 4];
        win_b  = req_if.req_b[4*i +: 4];
        win_op = req_if.req_op[2*i +: 2];
      end
    end
  end

  assign accept  = (state == IDLE) && found;
  assign capture = (state == WAIT) && (lat_cnt == 3'd0);

  always_comb begin
    ready_vec = '0;
    if (accept) ready_vec[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = WAIT;
      WAIT:    if (lat_cnt == 3'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      grant_id    <= '0;
      rr_ptr      <= '0;
      lat_cnt     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= '0;
      if (accept) begin
        alu_a    <= win_a;
        alu_b    <= win_b;
        alu_op   <= win_op;
        grant_id <= winner;
        rr_ptr   <= (winner == PW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        lat_cnt  <= 3'(ALU_LAT);
      end
      if ((state == WAIT) && (lat_cnt != 3'd0)) lat_cnt <= lat_cnt - 1'b1;
      // The result is returned bit-for-bit; an unsigned 4-bit sum overflow reads negative.
      if (capture) begin
        rsp_data_q            <= alu_c;
        rsp_valid_q[grant_id] <= 1'b1;
      end
    end
  end

  assign req_if.req_ready = ready_vec;
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_data  = rsp_data_q;
  assign busy             = (state != IDLE);
  assign dbg_state        = state;
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler with a registered stand-in ALU, a response
// scoreboard, a vector table for single operations and sequences for arbitration and reset.
module tb_alu_rr_scheduler;
  localparam int NUM_REQ = 4;
  localparam int ALU_LAT = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [3:0]        alu_a, alu_b;
  logic [1:0]        alu_op;
  logic signed [4:0] alu_c;
  logic              busy;
  logic [1:0]        grant_id;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] exp_q[$];
  logic [8:0] mon_word;
  logic [4:0] rr_exp[NUM_REQ];
  int         exp_ids[8];

  typedef struct {
    int         id;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [4:0] exp_c;
  } vec_t;
  vec_t vecs[7];

  alu_rr_scheduler_if #(.NUM_REQ(NUM_REQ)) rif ();

  alu_rr_scheduler #(.NUM_REQ(NUM_REQ), .ALU_LAT(ALU_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_if    (rif),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_c     (alu_c),
    .busy      (busy),
    .grant_id  (grant_id),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // Stand-in ALU: add, subtract, and, xor on zero-extended operands, ALU_LAT stages.
  function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    case (op)
      2'd0:    return {1'b0, a} + {1'b0, b};
      2'd1:    return {1'b0, a} - {1'b0, b};
      2'd2:    return {1'b0, a & b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  logic [4:0] alu_pipe[ALU_LAT];
  always @(posedge clk) begin
    alu_pipe[0] <= alu_f(alu_a, alu_b, alu_op);
    for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign alu_c = alu_pipe[ALU_LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every response pulse must match the oldest expected {rsp_valid, rsp_data}.
  always @(negedge clk) begin
    if (rif.rsp_valid !== '0) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", {rif.rsp_valid, $unsigned(rif.rsp_data)}, 32'd0);
      end else begin
        mon_word = exp_q.pop_front();
        check("rsp", {rif.rsp_valid, $unsigned(rif.rsp_data)}, mon_word);
      end
    end
  end

  // Driver tasks
  task automatic apply_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic do_op(input int id, input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] op, input logic [4:0] exp_c);
    int n;
    logic [3:0] mask;
    mask       = 4'(1 << id);
    rif.req_a  = (rif.req_a  & ~(16'hF << (4*id))) | (16'(a)  << (4*id));
    rif.req_b  = (rif.req_b  & ~(16'hF << (4*id))) | (16'(b)  << (4*id));
    rif.req_op = (rif.req_op & ~(8'h3  << (2*id))) | (8'(op)  << (2*id));
    rif.req_valid = rif.req_valid | mask;
    #1;
    n = 0;
    while ((rif.req_ready & mask) == '0 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("ready_wait", n, 0);
    check("req_ready", rif.req_ready, mask);
    exp_q.push_back({mask, exp_c});
    @(posedge clk); #1;
    rif.req_valid = rif.req_valid & ~mask;
    @(negedge clk);
    check("alu_operands", {alu_a, alu_b, alu_op}, {a, b, op});
    check("grant_id", grant_id, id);
    check("busy_wait", busy, 1);
    n = 1;
    while (rif.rsp_valid == '0 && n < 20) begin
      @(negedge clk); n++;
    end
    check("rsp_latency", n, ALU_LAT + 2);
    @(negedge clk);
    check("rsp_pulse_end", rif.rsp_valid, 0);
    check("busy_idle", busy, 0);
    check("rsp_data_hold", $unsigned(rif.rsp_data), exp_c);
  endtask

  // Watches n grants against exp_ids; raises requester raise_id after grant number raise_at.
  task automatic observe(input int n, input int raise_at, input int raise_id);
    int cnt, cyc, last, idx;
    cnt = 0; cyc = 0; last = 0;
    while (cnt < n && cyc < 100) begin
      #1;
      if (rif.req_ready != '0) begin
        idx = 0;
        for (int i = 0; i < NUM_REQ; i++) if (rif.req_ready[i]) idx = i;
        check("grant_onehot", $countones(rif.req_ready), 1);
        check("grant_order", idx, exp_ids[cnt]);
        if (cnt > 0) check("grant_gap", cyc - last, ALU_LAT + 3);
        last = cyc;
        exp_q.push_back({4'(1 << exp_ids[cnt]), rr_exp[exp_ids[cnt]]});
        cnt++;
        @(posedge clk); #1;
        if (cnt == raise_at) rif.req_valid = rif.req_valid | 4'(1 << raise_id);
        if (cnt == n) rif.req_valid = '0;
      end
      @(negedge clk);
      cyc++;
    end
    check("grant_count", cnt, n);
    rif.req_valid = '0;
    repeat (ALU_LAT + 4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{2, 4'd1,  4'd9,  2'd0, 5'd10};
    vecs[1] = '{0, 4'd15, 4'd15, 2'd0, 5'b11110};
    vecs[2] = '{1, 4'd3,  4'd5,  2'd1, 5'b11110};
    vecs[3] = '{3, 4'd12, 4'd10, 2'd2, 5'd8};
    vecs[4] = '{2, 4'd6,  4'd3,  2'd3, 5'd5};
    vecs[5] = '{1, 4'd0,  4'd0,  2'd0, 5'd0};
    vecs[6] = '{3, 4'd0,  4'd1,  2'd1, 5'b11111};
    rr_exp  = '{5'd4, 5'd29, 5'd3, 5'd13};

    rif.req_valid = '0;
    rif.req_a     = '0;
    rif.req_b     = '0;
    rif.req_op    = '0;

    // Reset: outputs cleared while held, nothing granted without requests afterwards
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_outputs", {rif.req_ready, rif.rsp_valid, $unsigned(rif.rsp_data), alu_a, alu_b,
                            alu_op, busy, grant_id, dbg_state}, 0);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_no_req", {rif.req_ready, busy, dbg_state}, 0);
    end

    // Single operations from the vector table, including overflow passthrough
    for (int v = 0; v < 7; v++) do_op(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].op, vecs[v].exp_c);

    // Round robin with every requester valid from reset
    apply_reset();
    rif.req_a  = {4'd4, 4'd3, 4'd2, 4'd1};
    rif.req_b  = {4'd9, 4'd7, 4'd5, 4'd3};
    rif.req_op = {2'd3, 2'd2, 2'd1, 2'd0};
    rif.req_valid = 4'b1111;
    exp_ids[0] = 0; exp_ids[1] = 1; exp_ids[2] = 2; exp_ids[3] = 3; exp_ids[4] = 0;
    observe(5, -1, 0);

    // Fairness and wrap: pointer moved to 2, then requesters 1 and 3, later 0 joins
    do_op(1, 4'd2, 4'd5, 2'd1, 5'd29);
    rif.req_valid = 4'b1010;
    exp_ids[0] = 3; exp_ids[1] = 1; exp_ids[2] = 3; exp_ids[3] = 1; exp_ids[4] = 3; exp_ids[5] = 0;
    observe(6, 5, 0);

    // Reset during WAIT aborts the operation and restarts the pointer at 0
    rif.req_valid = 4'b0100;
    #1;
    check("abort_ready", rif.req_ready, 4'b0100);
    @(posedge clk); #1;
    rif.req_valid = '0;
    @(negedge clk);
    check("abort_in_wait", {busy, dbg_state}, {1'b1, 2'd1});
    rst = 1'b0;
    #1;
    check("abort_outputs", {busy, rif.rsp_valid, dbg_state, grant_id, alu_a}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("abort_no_pulse", {rif.rsp_valid, busy}, 0);
    end
    rif.req_valid = 4'b1001;
    exp_ids[0] = 0; exp_ids[1] = 3;
    observe(2, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
